// File: rtl/enc_mes_window_if.sv
// Beat interface between the message generator and the message window:
// valid/ready handshake with start-of-frame, symbol count and lane data.
interface enc_mes_window_if #(
  parameter int SYM = 4,
  parameter int DIM = 8,
  parameter int CW  = $clog2(SYM + 1)
);
  logic                     valid;
  logic                     ready;
  logic                     sof;
  logic [CW-1:0]            cnt;
  logic [SYM-1:0][DIM-1:0]  data;

  modport master (output valid, output sof, output cnt, output data, input ready);
  modport slave  (input valid, input sof, input cnt, input data, output ready);
endinterface

// File: rtl/enc_mes_window.sv
// Message window for the RS encoder: shifts 0..SYM symbols per accepted beat
// into a DEP-symbol window (index 0 newest) and tracks a saturating fill level.
module enc_mes_window #(
  parameter int SYM = 4,
  parameter int DIM = 8,
  parameter int DEP = 16,
  parameter int CW  = $clog2(SYM + 1),
  parameter int FW  = $clog2(DEP + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     con_stall_i,
  input  logic                     clr_i,
  enc_mes_window_if.slave          in_if,
  output logic [DEP-1:0][DIM-1:0]  win_data_o,
  output logic [FW-1:0]            win_fill_o,
  output logic                     win_full_o,
  output logic                     win_new_o
);

  logic [DEP*DIM-1:0] win_q, win_d, win_base;
  logic [FW-1:0]      fill_q, fill_d;
  logic [FW:0]        fill_sum;
  logic               win_new_q, win_new_d;
  logic [CW-1:0]      n_eff;
  logic               accept;

  assign in_if.ready = !con_stall_i && !clr_i;
  assign accept      = in_if.valid && in_if.ready;

  // Start-of-frame treats the old contents as zero, so the shift base is
  // cleared before the new lanes are inserted at the newest end.
  always_comb begin
    n_eff    = (in_if.cnt > CW'(SYM)) ? CW'(SYM) : in_if.cnt;
    win_base = in_if.sof ? '0 : win_q;
    win_d    = win_base << (n_eff * DIM);
    for (int k = 0; k < SYM; k++) begin
      if (CW'(k) < n_eff) begin
        win_d[k*DIM +: DIM] = in_if.data[k];
      end
    end
    fill_sum = {1'b0, fill_q} + (FW+1)'(n_eff);
    if (in_if.sof) begin
      fill_d = FW'(n_eff);
    end else if (fill_sum > (FW+1)'(DEP)) begin
      fill_d = FW'(DEP);
    end else begin
      fill_d = fill_sum[FW-1:0];
    end
    win_new_d = accept && (n_eff != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q     <= '0;
      fill_q    <= '0;
      win_new_q <= 1'b0;
    end else if (!con_stall_i) begin
      if (clr_i) begin
        win_q     <= '0;
        fill_q    <= '0;
        win_new_q <= 1'b0;
      end else begin
        win_new_q <= win_new_d;
        if (accept) begin
          win_q  <= win_d;
          fill_q <= fill_d;
        end
      end
    end
  end

  assign win_data_o = win_q;
  assign win_fill_o = fill_q;
  assign win_full_o = (fill_q == FW'(DEP));
  assign win_new_o  = win_new_q;

endmodule

// File: tb/tb_enc_mes_window.sv
// Directed testbench for enc_mes_window: fill, saturation, start-of-frame,
// count clamping, stall/clear priority and asynchronous reset.
module tb_enc_mes_window;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              con_stall = 1'b0;
  logic              clr = 1'b0;
  logic [15:0][7:0]  win_data;
  logic [4:0]        win_fill;
  logic              win_full;
  logic              win_new;

  logic [15:0][7:0]  expWin;
  logic [3:0][7:0]   beat;
  int                passCount = 0;
  int                checkCount = 0;

  enc_mes_window_if #(.SYM(4), .DIM(8)) inIf ();

  enc_mes_window dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .con_stall_i (con_stall),
    .clr_i       (clr),
    .in_if       (inIf),
    .win_data_o  (win_data),
    .win_fill_o  (win_fill),
    .win_full_o  (win_full),
    .win_new_o   (win_new)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [15:0][7:0] eWin,
                            input int eFill, input logic eFull, input logic eNew);
    checkOutput({tag, "/win"},  128'(win_data), 128'(eWin));
    checkOutput({tag, "/fill"}, 128'(win_fill), 128'(eFill));
    checkOutput({tag, "/full"}, 128'(win_full), 128'(eFull));
    checkOutput({tag, "/new"},  128'(win_new),  128'(eNew));
  endtask

  // One beat offered at the falling edge, outputs sampled 1 time unit after
  // the accepting rising edge.
  task automatic applyStimulus(input logic sof, input logic [2:0] cnt,
                               input logic [3:0][7:0] data);
    @(negedge clk);
    inIf.valid = 1'b1;
    inIf.sof   = sof;
    inIf.cnt   = cnt;
    inIf.data  = data;
    @(posedge clk);
    #1;
    inIf.valid = 1'b0;
  endtask

  initial begin
    inIf.valid = 1'b0;
    inIf.sof   = 1'b0;
    inIf.cnt   = '0;
    inIf.data  = '0;

    #3;
    checkState("reset", '0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("readyIdle", 128'(inIf.ready), 128'(1'b1));

    // Four full beats carrying 0x01..0x10 in arrival order
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) beat[k] = 8'(4 * b + 4 - k);
      applyStimulus(1'b0, 3'd4, beat);
      checkOutput($sformatf("fill%0d", b), 128'(win_fill), 128'(4 * (b + 1)));
      checkOutput($sformatf("new%0d", b), 128'(win_new), 128'(1'b1));
    end
    for (int i = 0; i < 16; i++) expWin[i] = 8'(16 - i);
    checkState("fullWin", expWin, 16, 1'b1, 1'b1);

    beat = '0;
    beat[0] = 8'h20;
    beat[1] = 8'h21;
    beat[2] = 8'hEE;
    applyStimulus(1'b0, 3'd2, beat);
    expWin[0] = 8'h20;
    expWin[1] = 8'h21;
    for (int i = 2; i < 16; i++) expWin[i] = 8'(18 - i);
    checkState("satShift", expWin, 16, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checkState("idle", expWin, 16, 1'b1, 1'b0);

    // Start-of-frame on a full window, then build fill up to 10
    for (int k = 0; k < 4; k++) beat[k] = 8'(8'hA0 + k);
    applyStimulus(1'b1, 3'd4, beat);
    expWin = '0;
    for (int k = 0; k < 4; k++) expWin[k] = 8'(8'hA0 + k);
    checkState("sofFull", expWin, 4, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) beat[k] = 8'(8'hB0 + k);
    applyStimulus(1'b0, 3'd4, beat);
    for (int k = 0; k < 4; k++) beat[k] = 8'(8'hC0 + k);
    applyStimulus(1'b0, 3'd2, beat);
    checkOutput("fill10", 128'(win_fill), 128'(10));

    beat[0] = 8'h31;
    beat[1] = 8'h32;
    beat[2] = 8'h33;
    beat[3] = 8'hEE;
    applyStimulus(1'b1, 3'd3, beat);
    expWin = '0;
    expWin[0] = 8'h31;
    expWin[1] = 8'h32;
    expWin[2] = 8'h33;
    checkState("sofN3", expWin, 3, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd0, beat);
    checkState("sofN0", '0, 0, 1'b0, 1'b0);

    // Count above SYM clamps to SYM; count zero leaves the window alone
    for (int k = 0; k < 4; k++) beat[k] = 8'(8'hD0 + k);
    applyStimulus(1'b0, 3'd7, beat);
    expWin = '0;
    for (int k = 0; k < 4; k++) expWin[k] = 8'(8'hD0 + k);
    checkState("clamp", expWin, 4, 1'b0, 1'b1);
    beat = '1;
    applyStimulus(1'b0, 3'd0, beat);
    checkState("cnt0", expWin, 4, 1'b0, 1'b0);

    // Stall with a held beat and pending clear
    beat = '0;
    beat[0] = 8'hE0;
    applyStimulus(1'b0, 3'd1, beat);
    inIf.valid   = 1'b1;
    inIf.cnt     = 3'd2;
    inIf.data    = '0;
    inIf.data[0] = 8'hF0;
    inIf.data[1] = 8'hF1;
    con_stall    = 1'b1;
    clr          = 1'b1;
    #1;
    checkOutput("readyStall", 128'(inIf.ready), 128'(1'b0));
    expWin = '0;
    expWin[0] = 8'hE0;
    for (int k = 0; k < 4; k++) expWin[k + 1] = 8'(8'hD0 + k);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkState($sformatf("stall%0d", c), expWin, 5, 1'b0, 1'b1);
    end
    @(negedge clk);
    con_stall = 1'b0;
    #1;
    checkOutput("readyClr", 128'(inIf.ready), 128'(1'b0));
    @(posedge clk);
    #1;
    checkState("clear", '0, 0, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    checkOutput("readyRel", 128'(inIf.ready), 128'(1'b1));
    @(posedge clk);
    #1;
    inIf.valid = 1'b0;
    expWin = '0;
    expWin[0] = 8'hF0;
    expWin[1] = 8'hF1;
    checkState("heldBeat", expWin, 2, 1'b0, 1'b1);

    // Asynchronous reset at fill 12
    for (int k = 0; k < 4; k++) beat[k] = 8'(8'h40 + k);
    applyStimulus(1'b0, 3'd4, beat);
    applyStimulus(1'b0, 3'd4, beat);
    applyStimulus(1'b0, 3'd2, beat);
    checkOutput("fill12", 128'(win_fill), 128'(12));
    inIf.valid = 1'b1;
    inIf.cnt   = 3'd4;
    #2;
    rst_n = 1'b0;
    #1;
    checkState("asyncRst", '0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkState("holdRst", '0, 0, 1'b0, 1'b0);
    @(negedge clk);
    inIf.valid = 1'b0;
    rst_n = 1'b1;
    beat = '0;
    beat[0] = 8'h77;
    applyStimulus(1'b0, 3'd1, beat);
    expWin = '0;
    expWin[0] = 8'h77;
    checkState("postRst", expWin, 1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
